// File: rtl/bus_pkg.sv
// Shared bus package: FSM state encoding, bus mode constants and default
// frame widths. The serial slave port imports the same definitions so both
// ends agree on frame length and mode polarity.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } master_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEFAULT_ADDR_WIDTH     = 16;
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Every frame on wr_bus is address followed by a full data field,
  // including reads (whose data field is all zeros).
  function automatic int frame_bits(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parameterised MSB-first shift register with parallel load, shift enable,
// serial input at the LSB, serial output from the MSB and parallel output.
// Load wins over shift; with neither asserted the contents hold.
module bus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] sr_q;

  // Register: clear on reset, parallel load, or shift left by one bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= load_val;
    end else if (shift_en) begin
      sr_q <= {sr_q[WIDTH-2:0], ser_in};
    end
  end

  assign ser_out = sr_q[WIDTH-1];
  assign par_out = sr_q;

endmodule

// File: rtl/master_port.sv
// master_port: bus-side initiator for the serial slave ports.
// Accepts one parallel request, serialises {addr, data} MSB-first on wr_bus
// under master_valid/slave_ready, and for reads deserialises DATA_WIDTH bits
// from rd_bus under slave_valid/master_ready before pulsing rsp_valid.
//
// Handshake rule for both serial channels: a bit transfers on a rising edge
// where the sender's valid and the receiver's ready are both high; neither
// side may make its valid/ready depend combinationally on the other.
//
// Optional feature: define MASTER_PORT_TIMEOUT_EN to abort a transaction
// after TIMEOUT_CYCLES consecutive cycles without a handshake (rsp_err=1).
// dbg_state exposes the FSM state for observation.
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  input  logic                  slave_ready,
  input  logic                  rd_bus,
  input  logic                  slave_valid,
  output logic                  master_ready,
  output logic [1:0]            dbg_state
);

  localparam int FRAME_W = frame_bits(ADDR_WIDTH, DATA_WIDTH);
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] LAST_TX = CW'(FRAME_W - 1);
  localparam logic [CW-1:0] LAST_RX = CW'(DATA_WIDTH - 1);

  master_state_t         state_q;
  master_state_t         state_d;
  logic [CW-1:0]         cnt_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  tx_hs;
  logic                  rx_hs;
  logic                  tx_last;
  logic                  rx_last;
  logic                  timeout_hit;
  logic                  done_entry;

  logic [FRAME_W-1:0]    tx_load_val;
  logic                  tx_msb;
  logic [FRAME_W-1:0]    tx_par_unused;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  rx_ser_unused;
  logic                  rx_top_unused;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign tx_hs   = (state_q == ST_SEND) && slave_ready;
  assign rx_hs   = (state_q == ST_RECV) && slave_valid;
  assign tx_last = tx_hs && (cnt_q == LAST_TX);
  assign rx_last = rx_hs && (cnt_q == LAST_RX);

  // Any edge that moves the FSM into DONE: last write bit, last read bit,
  // or a stall timeout.
  assign done_entry = (tx_last && (mode_q == MODE_WRITE)) || rx_last || timeout_hit;

  // Reads still carry a zero data field so every frame has the same length.
  assign tx_load_val = {req_addr, (req_mode == MODE_WRITE) ? req_wdata : {DATA_WIDTH{1'b0}}};

  bus_shift_reg #(.WIDTH(FRAME_W)) u_tx_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (tx_load_val),
    .shift_en (tx_hs),
    .ser_in   (1'b0),
    .ser_out  (tx_msb),
    .par_out  (tx_par_unused)
  );

  bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ({DATA_WIDTH{1'b0}}),
    .shift_en (rx_hs),
    .ser_in   (rd_bus),
    .ser_out  (rx_ser_unused),
    .par_out  (rx_word)
  );

  // The final captured bit is folded in directly from rd_bus, so the MSB of
  // the receive register before that last shift is never needed.
  assign rx_top_unused = rx_word[DATA_WIDTH-1];

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_q;
  logic          busy;
  logic          stalled;
  logic          err_q;

  assign busy        = (state_q == ST_SEND) || (state_q == ST_RECV);
  assign stalled     = busy && !(tx_hs || rx_hs);
  assign timeout_hit = stalled && (stall_q == SW'(TIMEOUT_CYCLES - 1));

  // Count consecutive busy cycles without a handshake; any handshake or
  // leaving SEND/RECV restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stalled) begin
      stall_q <= stall_q + 1'b1;
    end else begin
      stall_q <= '0;
    end
  end

  // Error flag is captured when entering DONE and held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (done_entry) begin
      err_q <= timeout_hit;
    end
  end

  assign rsp_err = err_q;
`else
  logic [31:0] timeout_cycles_unused;

  assign timeout_cycles_unused = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign rsp_err               = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (timeout_hit) begin
          state_d = ST_DONE;
        end else if (tx_last) begin
          state_d = (mode_q == MODE_WRITE) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (timeout_hit || rx_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    req_ready    = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    rsp_valid    = 1'b0;
    wr_bus       = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_SEND: begin
        master_valid = 1'b1;
        wr_bus       = tx_msb;
      end
      ST_RECV: master_ready = 1'b1;
      ST_DONE: rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Bit counter: cleared on acceptance and between SEND and RECV, advanced
  // on each handshake. It stops at FRAME_W at most, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (tx_hs) begin
      if (tx_last && (mode_q == MODE_READ)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (rx_hs) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Bus mode only changes when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_READ;
    end else if (accept) begin
      mode_q <= req_mode;
    end
  end

  // Response data is set on entry to DONE: the completed read word, or zero
  // for writes and timeouts. It holds until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (done_entry) begin
      rdata_q <= rx_last ? {rx_word[DATA_WIDTH-2:0], rd_bus} : {DATA_WIDTH{1'b0}};
    end
  end

  assign mode      = mode_q;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/master_port.md
# master_port

Bus-side initiator that feeds the serial slave ports. It accepts one parallel request (mode, address, write data) per transaction from a local requester. It serialises address then data MSB-first onto `wr_bus` under the `master_valid`/`slave_ready` handshake. For reads, it deserialises the returned word from `rd_bus` under `slave_valid`/`master_ready` and returns it in parallel.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, address bits per frame
- `DATA_WIDTH`, 8, data bits per frame
- `TIMEOUT_CYCLES`, 64, stall limit; only used when the timeout feature is compiled in

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  local request present
- `req_ready`  out  1  block can accept a request
- `req_mode`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_WIDTH  target address
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes
- `rsp_err`  out  1  timeout flag; valid with `rsp_valid`
- `mode`  out  1  bus mode, held for the whole transaction
- `wr_bus`  out  1  serial address/data to slave
- `master_valid`  out  1  `wr_bus` bit valid
- `slave_ready`  in  1  slave accepts `wr_bus` bit
- `rd_bus`  in  1  serial read data from slave
- `slave_valid`  in  1  `rd_bus` bit valid
- `master_ready`  out  1  block accepts `rd_bus` bit

## Operation
- States: IDLE, SEND, RECV, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch the frame {`req_addr`, `req_wdata`} into a shift register (`req_wdata` replaced by zeros for reads).
  - Latch `req_mode` into `mode`, clear the bit counter, go to SEND.
- SEND:
  - `master_valid`=1; `wr_bus` = shift register MSB.
  - On each cycle with `slave_ready`=1: shift left one bit and increment the counter.
  - No handshake: hold the bit and the counter.
  - On the handshake of bit ADDR_WIDTH+DATA_WIDTH-1 (the last bit): go to DONE if `mode`=1, else clear the counter and go to RECV.
- RECV:
  - `master_ready`=1.
  - On each cycle with `slave_valid`=1: shift `rd_bus` into the LSB of the receive register and increment the counter.
  - After DATA_WIDTH captured bits, go to DONE.
  - A gap in `slave_valid` pauses capture; it does not abort.
- DONE:
  - `rsp_valid`=1 for one cycle, with `rsp_rdata` = received word (reads) or 0 (writes).
  - Go to IDLE.
- A read frame always carries DATA_WIDTH zero data bits, so every frame the slave sees is the same length.
- Counter width is `$clog2(ADDR_WIDTH+DATA_WIDTH+1)`. The counter is compared against constants and never wraps.
- `mode` changes only on request acceptance. `mode`, `rsp_rdata` and the shift registers hold their values in every other state.

## Timing
- Reset: state IDLE.
- Output values under reset:
  - `req_ready` 1
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0
  - `mode` 0, `wr_bus` 0
  - `master_valid` 0, `master_ready` 0
- Reset mid-transaction: abort immediately; no `rsp_valid` is issued.
- `master_valid`, `master_ready`, `req_ready` and `rsp_valid` are decoded from the registered state only, with no input-to-output combinational path.
- Request accepted at edge 0 → `master_valid` high from cycle 1.
- With no stalls, write completion takes N=ADDR_WIDTH+DATA_WIDTH handshakes: `rsp_valid` is asserted the cycle after the last handshake, and `req_ready` returns the cycle after that.
- Read completion takes N handshakes, then DATA_WIDTH `slave_valid` cycles. `rsp_valid` is asserted the cycle after the last capture.
- `slave_ready` or `slave_valid` held high outside SEND/RECV is ignored.
- Back-to-back requests: minimum one IDLE cycle between transactions.

## Configuration
- `MASTER_PORT_TIMEOUT_EN` defined:
  - In SEND and RECV, a counter counts consecutive cycles without a handshake and resets on every handshake.
  - When it reaches TIMEOUT_CYCLES: go to DONE with `rsp_err`=1 and `rsp_rdata`=0. `master_valid` and `master_ready` drop the following cycle.
- Not defined: no counter logic is generated; `rsp_err` is tied to 0 and the block waits indefinitely.

## Structure
- Shared package `bus_pkg`:
  - state enum `master_state_t`
  - constants `MODE_READ`=0, `MODE_WRITE`=1
  - default width constants; the slave port uses the same package
- One sub-module, `bus_shift_reg`: a parameterised shift register with load, shift-enable, serial in, serial out and parallel out. It is instantiated twice: once for the TX frame and once for the RX word.

## Test plan
- Write, no stalls, addr 0x00A5, data 0x3C, `slave_ready` always 1:
  - `wr_bus` sequence is 0000_0000_1010_0101 then 0011_1100.
  - `mode`=1 throughout; `rsp_valid` appears 1 cycle after the 24th handshake with `rsp_rdata`=0.
- Read addr 0x0012; slave returns 0xA7 on `rd_bus` after 5 idle cycles:
  - 24 bits are sent, the last 8 being zero.
  - `rsp_rdata`=0xA7 and `rsp_err`=0.
- `slave_ready` toggling 1/0 every cycle during a write:
  - every bit is held until handshaked; the frame is intact; completion takes 48 SEND cycles.
- `rst` asserted at bit 10 of a frame:
  - next cycle IDLE, `master_valid`=0, no `rsp_valid`.
  - A following write completes normally.
- `slave_valid` gap of 3 cycles after bit 4 of a read, data 0x5A → `rsp_rdata`=0x5A.
- With `MASTER_PORT_TIMEOUT_EN` and TIMEOUT_CYCLES=8, read with `slave_valid` never asserted → `rsp_valid` with `rsp_err`=1 exactly 8 cycles after entering RECV.
